// File: rtl/lsu_dram_port.sv
// Load/store unit port onto a single-ported DRAM: IDLE -> ACCESS -> (WAIT) -> RESP handshake FSM.
// Optional macro LSU_MISALIGN_TRAP_EN rejects misaligned half/word accesses instead of truncating the offset.
module lsu_dram_port #(
    parameter int RD_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        dram_en,
    output logic        dram_wen,
    output logic [31:0] dram_addr,
    output logic [31:0] dram_wdata,
    output logic [31:0] dram_wmask,
    input  logic [31:0] dram_rdata
);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_RESP} state_t;

    localparam logic [2:0] LAT_C = 3'(RD_LAT);

    state_t      r_state;
    logic        r_wen;
    logic [1:0]  r_size;
    logic        r_uns;
    logic [1:0]  r_off;
    logic [2:0]  r_cnt;
    logic        r_req_ready;
    logic        r_resp_valid;
    logic        r_resp_err;
    logic [31:0] r_resp_rdata;
    logic        r_dram_en;
    logic        r_dram_wen;
    logic [31:0] r_dram_addr;
    logic [31:0] r_dram_wdata;
    logic [31:0] r_dram_wmask;

    logic        w_misalign;
    logic        w_err;
    logic [31:0] w_wdata;
    logic [31:0] w_wmask;

    function automatic logic [31:0] f_load_align(input logic [31:0] word, input logic [1:0] size,
                                                 input logic uns, input logic [1:0] off);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        b = word[{off, 3'b000} +: 8];
        h = off[1] ? word[31:16] : word[15:0];
        case (size)
            2'd0:    res = {{24{~uns & b[7]}}, b};
            2'd1:    res = {{16{~uns & h[15]}}, h};
            default: res = word;
        endcase
        return res;
    endfunction

`ifdef LSU_MISALIGN_TRAP_EN
    assign w_misalign = ((req_size == 2'd1) && req_addr[0]) ||
                        ((req_size == 2'd2) && (req_addr[1:0] != 2'b00));
`else
    assign w_misalign = 1'b0;
`endif
    assign w_err = (req_size == 2'd3) || w_misalign;

    // Store lane replication and byte-enable mask, formed from the request as it is accepted.
    always_comb begin
        w_wdata = req_wdata;
        w_wmask = 32'hFFFF_FFFF;
        case (req_size)
            2'd0: begin
                w_wdata = {4{req_wdata[7:0]}};
                w_wmask = 32'h0000_00FF << {req_addr[1:0], 3'b000};
            end
            2'd1: begin
                w_wdata = {2{req_wdata[15:0]}};
                w_wmask = 32'h0000_FFFF << {req_addr[1], 4'b0000};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_wen        <= 1'b0;
            r_size       <= 2'd0;
            r_uns        <= 1'b0;
            r_off        <= 2'd0;
            r_cnt        <= 3'd0;
            r_req_ready  <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= 32'd0;
            r_dram_en    <= 1'b0;
            r_dram_wen   <= 1'b0;
            r_dram_addr  <= 32'd0;
            r_dram_wdata <= 32'd0;
            r_dram_wmask <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid && r_req_ready) begin
                        r_req_ready <= 1'b0;
                        r_wen       <= req_wen;
                        r_size      <= req_size;
                        r_uns       <= req_unsigned;
                        r_off       <= req_addr[1:0];
                        if (w_err) begin
                            r_state      <= S_RESP;
                            r_resp_valid <= 1'b1;
                            r_resp_err   <= 1'b1;
                            r_resp_rdata <= 32'd0;
                        end else begin
                            r_state      <= S_ACCESS;
                            r_dram_en    <= 1'b1;
                            r_dram_wen   <= req_wen;
                            r_dram_addr  <= {req_addr[31:2], 2'b00};
                            r_dram_wdata <= req_wen ? w_wdata : 32'd0;
                            r_dram_wmask <= req_wen ? w_wmask : 32'd0;
                        end
                    end else begin
                        r_req_ready <= 1'b1;
                    end
                end
                S_ACCESS: begin
                    r_dram_en    <= 1'b0;
                    r_dram_wen   <= 1'b0;
                    r_dram_addr  <= 32'd0;
                    r_dram_wdata <= 32'd0;
                    r_dram_wmask <= 32'd0;
                    if (r_wen) begin
                        r_state      <= S_RESP;
                        r_resp_valid <= 1'b1;
                        r_resp_err   <= 1'b0;
                        r_resp_rdata <= 32'd0;
                    end else begin
                        r_state <= S_WAIT;
                        r_cnt   <= 3'd1;
                    end
                end
                S_WAIT: begin
                    if (r_cnt == LAT_C) begin
                        r_state      <= S_RESP;
                        r_cnt        <= 3'd0;
                        r_resp_valid <= 1'b1;
                        r_resp_err   <= 1'b0;
                        r_resp_rdata <= f_load_align(dram_rdata, r_size, r_uns, r_off);
                    end else begin
                        r_cnt <= r_cnt + 3'd1;
                    end
                end
                S_RESP: begin
                    if (resp_ready) begin
                        r_state      <= S_IDLE;
                        r_resp_valid <= 1'b0;
                        r_resp_err   <= 1'b0;
                        r_resp_rdata <= 32'd0;
                        r_req_ready  <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign req_ready  = r_req_ready;
    assign resp_valid = r_resp_valid;
    assign resp_err   = r_resp_err;
    assign resp_rdata = r_resp_rdata;
    assign dram_en    = r_dram_en;
    assign dram_wen   = r_dram_wen;
    assign dram_addr  = r_dram_addr;
    assign dram_wdata = r_dram_wdata;
    assign dram_wmask = r_dram_wmask;

endmodule

// File: tb/tb_lsu_dram_port.sv
// Scoreboard bench for lsu_dram_port: directed vectors push expected DRAM accesses and responses,
// two monitors pop and compare whenever the DUT presents them.
module tb_lsu_dram_port;

    localparam int RD_LAT = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_wen = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        resp_valid;
    logic        resp_ready = 1'b1;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        dram_en;
    logic        dram_wen;
    logic [31:0] dram_addr;
    logic [31:0] dram_wdata;
    logic [31:0] dram_wmask;
    logic [31:0] dram_rdata;

    always #5 clk = ~clk;

    lsu_dram_port #(.RD_LAT(RD_LAT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
        .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .dram_en(dram_en), .dram_wen(dram_wen), .dram_addr(dram_addr),
        .dram_wdata(dram_wdata), .dram_wmask(dram_wmask), .dram_rdata(dram_rdata)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // One-cycle read model: data is only valid the cycle after a read access, garbage otherwise.
    logic [31:0] mem_word = 32'd0;
    logic [31:0] rd_pipe;
    always @(posedge clk or negedge rst) begin
        if (!rst) rd_pipe <= 32'h5A5A_5A5A;
        else      rd_pipe <= (dram_en && !dram_wen) ? mem_word : 32'h5A5A_5A5A;
    end
    assign dram_rdata = rd_pipe;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct packed {
        logic        wen;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] mem;
        logic        dram;
        logic [31:0] d_addr;
        logic [31:0] d_wdata;
        logic [31:0] d_mask;
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } vec_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } resp_t;

    typedef struct packed {
        logic [31:0] addr;
        logic        wen;
        logic [31:0] wdata;
        logic [31:0] mask;
        int          cyc;
    } dacc_t;

    resp_t rq[$];
    dacc_t dq[$];

    initial begin : resp_monitor
        bit first;
        first = 1'b1;
        forever begin
            @(negedge clk);
            if (resp_valid) begin
                if (rq.size() == 0) begin
                    chk("resp_unexpected", {31'd0, resp_valid}, 32'd0);
                end else begin
                    if (first) chk("resp_latency", cyc, rq[0].cyc);
                    chk("resp_rdata", resp_rdata, rq[0].rdata);
                    chk("resp_err", {31'd0, resp_err}, {31'd0, rq[0].err});
                    chk("req_ready_busy", {31'd0, req_ready}, 32'd0);
                    first = 1'b0;
                    if (resp_ready) begin
                        void'(rq.pop_front());
                        first = 1'b1;
                    end
                end
            end
        end
    end

    initial begin : dram_monitor
        dacc_t d;
        forever begin
            @(negedge clk);
            if (dram_en) begin
                if (dq.size() == 0) begin
                    chk("dram_unexpected", {31'd0, dram_en}, 32'd0);
                end else begin
                    d = dq.pop_front();
                    chk("dram_cycle", cyc, d.cyc);
                    chk("dram_addr", dram_addr, d.addr);
                    chk("dram_wen", {31'd0, dram_wen}, {31'd0, d.wen});
                    chk("dram_wmask", dram_wmask, d.mask);
                    if (d.wen) chk("dram_wdata", dram_wdata, d.wdata);
                end
            end else if (dram_wen) begin
                chk("dram_wen_outside_access", {31'd0, dram_wen}, 32'd0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input vec_t v, input bit want_resp, output int acc);
        dacc_t d;
        resp_t r;
        mem_word     = v.mem;
        req_wen      = v.wen;
        req_size     = v.size;
        req_unsigned = v.uns;
        req_addr     = v.addr;
        req_wdata    = v.wdata;
        req_valid    = 1'b1;
        for (int i = 0; i < 50 && !req_ready; i++) tick();
        if (!req_ready) chk("req_ready_timeout", {31'd0, req_ready}, 32'd1);
        acc = cyc + 1;
        if (v.dram) begin
            d = '{addr: v.d_addr, wen: v.wen, wdata: v.d_wdata, mask: v.d_mask, cyc: acc};
            dq.push_back(d);
        end
        if (want_resp) begin
            r = '{rdata: v.rdata, err: v.err, cyc: acc + v.lat - 1};
            rq.push_back(r);
        end
        tick();
        // Scramble request fields after acceptance; the latched transaction must not change.
        req_valid    = 1'b0;
        req_wen      = 1'($urandom);
        req_size     = 2'($urandom);
        req_unsigned = 1'($urandom);
        req_addr     = $urandom;
        req_wdata    = $urandom;
    endtask

    task automatic drain();
        for (int i = 0; i < 50 && (rq.size() != 0 || dq.size() != 0); i++) tick();
        if (rq.size() != 0 || dq.size() != 0)
            chk("drain_timeout", 32'(rq.size() + dq.size()), 32'd0);
        rq.delete();
        dq.delete();
    endtask

    task automatic run(input vec_t v);
        int acc;
        issue(v, 1'b1, acc);
        drain();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_req_ready"},  {31'd0, req_ready},  32'd0);
        chk({tag, "_resp_valid"}, {31'd0, resp_valid}, 32'd0);
        chk({tag, "_resp_err"},   {31'd0, resp_err},   32'd0);
        chk({tag, "_resp_rdata"}, resp_rdata,          32'd0);
        chk({tag, "_dram_en"},    {31'd0, dram_en},    32'd0);
        chk({tag, "_dram_wen"},   {31'd0, dram_wen},   32'd0);
        chk({tag, "_dram_addr"},  dram_addr,           32'd0);
        chk({tag, "_dram_wdata"}, dram_wdata,          32'd0);
        chk({tag, "_dram_wmask"}, dram_wmask,          32'd0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        vec_t v;
        int   acc;
        localparam int LD = RD_LAT + 2;

        tick();
        tick();
        chk_all_zero("reset");
        rst = 1'b1;
        tick();
        chk("req_ready_after_reset", {31'd0, req_ready}, 32'd1);

        // wen size uns addr wdata mem | dram d_addr d_wdata d_mask | rdata err lat
        v = '{1'b1, 2'd2, 1'b0, 32'h8000_0004, 32'hDEAD_BEEF, 32'd0,
              1'b1, 32'h8000_0004, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 32'd0, 1'b0, 2};
        run(v);
        v = '{1'b1, 2'd0, 1'b0, 32'h8000_0003, 32'hFFFF_00A5, 32'd0,
              1'b1, 32'h8000_0000, 32'hA5A5_A5A5, 32'hFF00_0000, 32'd0, 1'b0, 2};
        run(v);
        v = '{1'b1, 2'd0, 1'b0, 32'h0000_0041, 32'h0000_007E, 32'd0,
              1'b1, 32'h0000_0040, 32'h7E7E_7E7E, 32'h0000_FF00, 32'd0, 1'b0, 2};
        run(v);
        v = '{1'b1, 2'd1, 1'b0, 32'h0000_0002, 32'hAAAA_1234, 32'd0,
              1'b1, 32'h0000_0000, 32'h1234_1234, 32'hFFFF_0000, 32'd0, 1'b0, 2};
        run(v);
        v = '{1'b0, 2'd0, 1'b0, 32'h0010_0002, 32'd0, 32'h12F4_5678,
              1'b1, 32'h0010_0000, 32'd0, 32'd0, 32'hFFFF_FFF4, 1'b0, LD};
        run(v);
        v = '{1'b0, 2'd0, 1'b1, 32'h0010_0002, 32'd0, 32'h12F4_5678,
              1'b1, 32'h0010_0000, 32'd0, 32'd0, 32'h0000_00F4, 1'b0, LD};
        run(v);
        v = '{1'b0, 2'd0, 1'b0, 32'h0000_0010, 32'd0, 32'h0000_007F,
              1'b1, 32'h0000_0010, 32'd0, 32'd0, 32'h0000_007F, 1'b0, LD};
        run(v);
        v = '{1'b0, 2'd1, 1'b0, 32'h0000_0006, 32'd0, 32'h8001_7FFF,
              1'b1, 32'h0000_0004, 32'd0, 32'd0, 32'hFFFF_8001, 1'b0, LD};
        run(v);
        v = '{1'b0, 2'd1, 1'b1, 32'h0000_0008, 32'd0, 32'h1234_8765,
              1'b1, 32'h0000_0008, 32'd0, 32'd0, 32'h0000_8765, 1'b0, LD};
        run(v);
        v = '{1'b0, 2'd2, 1'b0, 32'h0000_000C, 32'd0, 32'hCAFE_F00D,
              1'b1, 32'h0000_000C, 32'd0, 32'd0, 32'hCAFE_F00D, 1'b0, LD};
        run(v);

`ifdef LSU_MISALIGN_TRAP_EN
        v = '{1'b0, 2'd1, 1'b0, 32'h0000_0015, 32'd0, 32'hABCD_9876,
              1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b1, 1};
        run(v);
        v = '{1'b1, 2'd2, 1'b0, 32'h0000_0023, 32'h1122_3344, 32'd0,
              1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b1, 1};
        run(v);
`else
        v = '{1'b0, 2'd1, 1'b0, 32'h0000_0015, 32'd0, 32'hABCD_9876,
              1'b1, 32'h0000_0014, 32'd0, 32'd0, 32'hFFFF_9876, 1'b0, LD};
        run(v);
        v = '{1'b1, 2'd2, 1'b0, 32'h0000_0023, 32'h1122_3344, 32'd0,
              1'b1, 32'h0000_0020, 32'h1122_3344, 32'hFFFF_FFFF, 32'd0, 1'b0, 2};
        run(v);
`endif

        v = '{1'b0, 2'd3, 1'b0, 32'h0000_0030, 32'd0, 32'h7777_7777,
              1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b1, 1};
        run(v);
        v = '{1'b1, 2'd3, 1'b0, 32'h0000_0034, 32'hFFFF_FFFF, 32'd0,
              1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b1, 1};
        run(v);

        // Back-pressure: response must hold while resp_ready stays low.
        resp_ready = 1'b0;
        v = '{1'b0, 2'd2, 1'b0, 32'h0000_0040, 32'd0, 32'h600D_F00D,
              1'b1, 32'h0000_0040, 32'd0, 32'd0, 32'h600D_F00D, 1'b0, LD};
        issue(v, 1'b1, acc);
        for (int i = 0; i < 20 && !resp_valid; i++) tick();
        repeat (5) tick();
        chk("resp_held_valid", {31'd0, resp_valid}, 32'd1);
        resp_ready = 1'b1;
        drain();

        // Reset in the middle of a load's WAIT state: the transaction is dropped.
        v = '{1'b0, 2'd2, 1'b0, 32'h0000_0050, 32'd0, 32'h1234_5678,
              1'b1, 32'h0000_0050, 32'd0, 32'd0, 32'd0, 1'b0, LD};
        issue(v, 1'b0, acc);
        tick();
        rst = 1'b0;
        #1;
        chk_all_zero("midreset");
        tick();
        tick();
        rst = 1'b1;
        chk("req_ready_in_release", {31'd0, req_ready}, 32'd0);
        tick();
        chk("req_ready_after_midreset", {31'd0, req_ready}, 32'd1);
        repeat (6) tick();
        drain();

        v = '{1'b1, 2'd0, 1'b0, 32'h0000_0061, 32'h0000_003C, 32'd0,
              1'b1, 32'h0000_0060, 32'h3C3C_3C3C, 32'h0000_FF00, 32'd0, 1'b0, 2};
        run(v);

        repeat (3) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lsu_dram_port.md
LSU_DRAM_PORT -- requirements
Module: lsu_dram_port

Interface
REQ-001 Parameter RD_LAT, default 1, number of cycles from a read cycle with dram_en high to valid dram_rdata; legal range 1..4.
REQ-002 clk  in  1  sole clock; all state updates on the rising edge.
REQ-003 rst  in  1  reset; asynchronous assert, active-low (0 = reset), released synchronously to clk by the system.
REQ-004 req_valid  in  1  core has a memory request.
REQ-005 req_ready  out  1  block accepts a request this cycle.
REQ-006 req_wen  in  1  1 = store, 0 = load.
REQ-007 req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = reserved.
REQ-008 req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
REQ-009 req_addr  in  32  byte address; req_wdata  in  32  store data in the low bits.
REQ-010 resp_valid  out  1  response available; resp_ready  in  1  core consumes response.
REQ-011 resp_rdata  out  32  aligned and extended load data (0 for stores); resp_err  out  1  access was rejected.
REQ-012 dram_en, dram_wen  out  1 each; dram_addr, dram_wdata, dram_wmask  out  32 each; dram_rdata  in  32; these connect directly to the existing DRAM port.

Function
REQ-013 FSM states: IDLE, ACCESS, WAIT, RESP; req_ready = 1 only in IDLE.
REQ-014 IDLE: on req_valid & req_ready, latch all req_* fields and go to ACCESS; otherwise hold.
REQ-015 ACCESS (exactly one cycle): dram_en = 1, dram_wen = latched req_wen, dram_addr = {addr[31:2], 2'b00}; a store goes to RESP, a load goes to WAIT.
REQ-016 dram_en and dram_wen SHALL be 0 in every state other than ACCESS.
REQ-017 WAIT: counter starts at 1 in the cycle after ACCESS; when the counter equals RD_LAT, sample dram_rdata into the response register and go to RESP; otherwise increment.
REQ-018 Byte store: dram_wdata = {4{wdata[7:0]}}, dram_wmask = 0xFF << (8*addr[1:0]).
REQ-019 Half store: dram_wdata = {2{wdata[15:0]}}, dram_wmask = 0xFFFF << (16*addr[1]).
REQ-020 Word store: dram_wdata = wdata, dram_wmask = 0xFFFFFFFF; dram_wmask = 0 for loads.
REQ-021 Load alignment: select byte addr[1:0] or half addr[1] of the sampled word, then extend per req_unsigned to 32 bits.
REQ-022 RESP: resp_valid = 1, holding resp_rdata and resp_err stable until resp_ready = 1; on resp_ready go to IDLE (the next request is accepted no earlier than the following cycle).
REQ-023 req_size = 3 is handled as an error: skip ACCESS and go directly to RESP with resp_err = 1 and resp_rdata = 0.
REQ-024 req_* inputs are ignored outside IDLE; latched values remain unaffected by input changes.
REQ-025 Total latency request-accept to resp_valid: store 2 cycles, load RD_LAT+2 cycles.

Reset
REQ-026 While rst = 0: state = IDLE; req_ready, resp_valid, resp_err, dram_en, dram_wen = 0; resp_rdata, dram_addr, dram_wdata, dram_wmask = 0; WAIT counter = 0.
REQ-027 rst asserted mid-transaction aborts it: no DRAM access completes after assertion and no response is produced.
REQ-028 req_ready rises in the first cycle after rst returns to 1.

Configuration
REQ-029 Macro LSU_MISALIGN_TRAP_EN: when defined, a half access with addr[0] = 1 or a word access with addr[1:0] != 0 skips ACCESS and goes to RESP with resp_err = 1, resp_rdata = 0, and no DRAM write.
REQ-030 When LSU_MISALIGN_TRAP_EN is undefined, the offending low address bits are treated as 0 (a half uses addr[1] only; a word uses offset 0), the access proceeds normally, and resp_err is 1 only for req_size = 3.

Verification
REQ-031 Word store: addr 0x80000004, wdata 0xDEADBEEF -> one ACCESS cycle with dram_addr 0x80000004, wmask 0xFFFFFFFF; resp_valid 2 cycles after accept.
REQ-032 Byte store: addr 0x80000003, wdata 0x000000A5 -> dram_wdata 0xA5A5A5A5, dram_wmask 0xFF000000.
REQ-033 Signed byte load: dram_rdata 0x12F45678, addr offset 2, RD_LAT = 1 -> resp_rdata 0xFFFFFFF4; the unsigned variant returns 0x000000F4.
REQ-034 Half load at offset 1 with LSU_MISALIGN_TRAP_EN defined -> resp_err 1, dram_en never asserted; with it undefined -> offset 0 data returned, resp_err 0.
REQ-035 resp_ready held at 0 for 5 cycles -> resp_valid and data stable throughout, req_ready 0; rst pulsed low during WAIT -> all outputs 0 immediately, no response after release.
